// File: rtl/mem_test_pkg.sv
// Shared types and default sizing for the memory data-bus tester access adapter.
// Contents:
//   mem_acc_state_t        adapter FSM state encoding
//   DEFAULT_DATUM_WIDTH    default data word width
//   DEFAULT_ADDR_WIDTH     default memory address width
//   DEFAULT_TIMEOUT_CYCLES default per-transaction ack wait limit
package mem_test_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    TIMEOUT = 2'd3
  } mem_acc_state_t;

  localparam int DEFAULT_DATUM_WIDTH    = 8;
  localparam int DEFAULT_ADDR_WIDTH     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/mem_test_timeout_cnt.sv
// Saturating wait counter for the access adapter.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   clr   in  synchronous clear to zero (wins over en)
//   en    in  count enable, one step per cycle
//   tc    out count has reached TIMEOUT_CYCLES-1 (terminal count)
module mem_test_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TC_VAL = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt;

  // Holds at TC_VAL instead of wrapping, so tc stays asserted until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TC_VAL)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mem_test_access_adapter.sv
// Access adapter between the walking-ones data-bus tester and a req/ack memory port.
// Each tester request becomes one memory transaction; a stuck memory is caught by a
// per-transaction timeout that raises a sticky o_timeout.
// Ports:
//   i_clk, i_rst_async            clock and asynchronous active-high reset
//   i_wr_req, i_rd_req            request pulses from the tester (sampled in IDLE)
//   i_clear                       clears o_timeout; leaves TIMEOUT back to IDLE
//   i_address, i_wr_data          request address and write data
//   o_write_ready, o_read_valid   one-cycle completion pulses
//   o_read_data                   last read word, held until the next read
//   o_busy, o_timeout             status
//   o_mem_req/we/addr/wdata       memory request side (all registered)
//   i_mem_ack, i_mem_rdata        memory completion and read data
//
// state   | meaning
// IDLE    | waiting for a tester request
// WR_WAIT | write issued, waiting for ack
// RD_WAIT | read issued (or about to be re-issued after a read-back write)
// TIMEOUT | ack never came; parked until i_clear
module mem_test_access_adapter
  import mem_test_pkg::*;
#(
  parameter int DATUM_WIDTH    = DEFAULT_DATUM_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst_async,
  input  logic                   i_wr_req,
  input  logic                   i_rd_req,
  input  logic                   i_clear,
  input  logic [ADDR_WIDTH-1:0]  i_address,
  input  logic [DATUM_WIDTH-1:0] i_wr_data,
  output logic                   o_write_ready,
  output logic                   o_read_valid,
  output logic [DATUM_WIDTH-1:0] o_read_data,
  output logic                   o_busy,
  output logic                   o_timeout,
  output logic                   o_mem_req,
  output logic                   o_mem_we,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic [DATUM_WIDTH-1:0] o_mem_wdata,
  input  logic                   i_mem_ack,
  input  logic [DATUM_WIDTH-1:0] i_mem_rdata
);

  mem_acc_state_t         state, state_n;
  logic                   pend_rd, pend_rd_n;
  logic                   req_n, we_n, wr_ready_n, rd_valid_n, timeout_n;
  logic [ADDR_WIDTH-1:0]  addr_n;
  logic [DATUM_WIDTH-1:0] wdata_n, rdata_n;
  logic                   cnt_clr, cnt_tc;

  mem_test_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk (i_clk),
    .rst (i_rst_async),
    .clr (cnt_clr),
    .en  (o_mem_req),
    .tc  (cnt_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst_async) begin
    if (i_rst_async) begin
      state         <= IDLE;
      pend_rd       <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_read_data   <= '0;
      o_write_ready <= 1'b0;
      o_read_valid  <= 1'b0;
      o_timeout     <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_n;
      pend_rd       <= pend_rd_n;
      o_mem_req     <= req_n;
      o_mem_we      <= we_n;
      o_mem_addr    <= addr_n;
      o_mem_wdata   <= wdata_n;
      o_read_data   <= rdata_n;
      o_write_ready <= wr_ready_n;
      o_read_valid  <= rd_valid_n;
      o_timeout     <= timeout_n;
      o_busy        <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n    = state;
    pend_rd_n  = pend_rd;
    req_n      = o_mem_req;
    we_n       = o_mem_we;
    addr_n     = o_mem_addr;
    wdata_n    = o_mem_wdata;
    rdata_n    = o_read_data;
    wr_ready_n = 1'b0;
    rd_valid_n = 1'b0;
    timeout_n  = o_timeout;
    cnt_clr    = 1'b0;

    if (i_clear) begin
      timeout_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (i_wr_req) begin
          state_n   = WR_WAIT;
          req_n     = 1'b1;
          we_n      = 1'b1;
          addr_n    = i_address;
          wdata_n   = i_wr_data;
          pend_rd_n = i_rd_req;
          cnt_clr   = 1'b1;
        end else if (i_rd_req) begin
          state_n = RD_WAIT;
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = i_address;
          cnt_clr = 1'b1;
        end
      end

      WR_WAIT: begin
        // Ack is checked before terminal count so a last-cycle ack still completes.
        if (i_mem_ack) begin
          req_n      = 1'b0;
          we_n       = 1'b0;
          wr_ready_n = 1'b1;
          pend_rd_n  = 1'b0;
          state_n    = pend_rd ? RD_WAIT : IDLE;
        end else if (cnt_tc) begin
          state_n   = TIMEOUT;
          req_n     = 1'b0;
          we_n      = 1'b0;
          timeout_n = 1'b1;
          pend_rd_n = 1'b0;
        end
      end

      RD_WAIT: begin
        // After a read-back write, req is low for one cycle: re-raise it here so the
        // memory sees a fresh request edge and the wait counter restarts.
        if (!o_mem_req) begin
          req_n   = 1'b1;
          cnt_clr = 1'b1;
        end else if (i_mem_ack) begin
          req_n      = 1'b0;
          rdata_n    = i_mem_rdata;
          rd_valid_n = 1'b1;
          state_n    = IDLE;
        end else if (cnt_tc) begin
          state_n   = TIMEOUT;
          req_n     = 1'b0;
          timeout_n = 1'b1;
          pend_rd_n = 1'b0;
        end
      end

      TIMEOUT: begin
        if (i_clear) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_test_access_adapter.sv
module tb_mem_test_access_adapter;
  import mem_test_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, rd_req, clr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          write_ready, read_valid, busy, timeout;
  logic [DW-1:0] read_data;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_test_access_adapter #(
    .DATUM_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC)
  ) dut (
    .i_clk(clk), .i_rst_async(rst),
    .i_wr_req(wr_req), .i_rd_req(rd_req), .i_clear(clr),
    .i_address(addr), .i_wr_data(wdata),
    .o_write_ready(write_ready), .o_read_valid(read_valid),
    .o_read_data(read_data), .o_busy(busy), .o_timeout(timeout),
    .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model + monitor, all evaluated on the falling edge.
  logic [DW-1:0] mem [256];
  int            mem_ack_delay = 0;
  logic          model_ack = 1'b0;
  logic          force_ack = 1'b0;
  int            req_cycles = 0;
  int            n_mem_wr, n_mem_rd, n_wr_ready, n_rd_valid, run, max_run, n_busy_fall, we_flips;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_data;
  logic          prev_req = 1'b0, prev_we = 1'b0, prev_busy = 1'b0;

  assign mem_ack = model_ack | force_ack;

  always @(negedge clk) begin
    if (mem_req) begin
      req_cycles++;
      if (prev_req && (mem_we != prev_we)) we_flips++;
      if (mem_ack_delay != 0 && req_cycles == mem_ack_delay) begin
        model_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          last_wr_addr  = mem_addr;
          last_wr_data  = mem_wdata;
          n_mem_wr++;
        end else begin
          mem_rdata = mem[mem_addr];
          n_mem_rd++;
        end
      end else begin
        model_ack = 1'b0;
      end
    end else begin
      req_cycles = 0;
      model_ack  = 1'b0;
    end
    prev_req = mem_req;
    prev_we  = mem_we;
    if (write_ready) n_wr_ready++;
    if (read_valid)  n_rd_valid++;
    if (mem_req) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (prev_busy && !busy) n_busy_fall++;
    prev_busy = busy;
  end

  task automatic clear_stats();
    n_mem_wr = 0; n_mem_rd = 0; n_wr_ready = 0; n_rd_valid = 0;
    run = 0; max_run = 0; n_busy_fall = 0; we_flips = 0;
    last_wr_addr = '0; last_wr_data = '0;
  endtask

  // Called right after a falling edge. Issues one request pulse and waits (bounded)
  // until the adapter is idle again or has timed out, then lets two more cycles pass.
  task automatic do_txn(input logic w, input logic r, input logic [7:0] a,
                        input logic [7:0] d, input int dly);
    bit done = 0;
    mem_ack_delay = dly;
    wr_req = w; rd_req = r; addr = a; wdata = d;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy || timeout) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_wait_bound: adapter still busy after 40 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic       wr, rd;
    logic [7:0] addr, wdata;
    int         ack_dly;
    int         exp_wr_ready, exp_rd_valid, exp_mem_wr, exp_mem_rd;
    logic       exp_timeout;
    logic [7:0] exp_rdata;
    int         exp_run, exp_busy_fall;
  } vec_t;

  vec_t vecs[9];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = ~(8'(i));
    rst = 1'b1; wr_req = 0; rd_req = 0; clr = 0; addr = '0; wdata = '0; mem_rdata = '0;
    clear_stats();

    //          wr    rd    addr   wdata  dly wrr rdv mw mr  to    rdata  run fall
    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h01, 2,  1,  0,  1, 0, 1'b0, 8'h00, 2,  1};
    vecs[1] = '{1'b0, 1'b1, 8'h10, 8'h00, 1,  0,  1,  0, 1, 1'b0, 8'h01, 1,  1};
    vecs[2] = '{1'b1, 1'b1, 8'h20, 8'h80, 3,  1,  1,  1, 1, 1'b0, 8'h80, 3,  1};
    vecs[3] = '{1'b0, 1'b1, 8'h22, 8'h00, 5,  0,  1,  0, 1, 1'b0, 8'hDD, 5,  1};
    vecs[4] = '{1'b1, 1'b0, 8'h30, 8'h55, 8,  1,  0,  1, 0, 1'b0, 8'hDD, 8,  1};
    vecs[5] = '{1'b1, 1'b0, 8'h31, 8'hAA, 0,  0,  0,  0, 0, 1'b1, 8'hDD, 8,  0};
    vecs[6] = '{1'b0, 1'b1, 8'h30, 8'h00, 9,  0,  0,  0, 0, 1'b1, 8'hDD, 8,  0};
    vecs[7] = '{1'b1, 1'b1, 8'h40, 8'h3C, 1,  1,  1,  1, 1, 1'b0, 8'h3C, 1,  1};
    vecs[8] = '{1'b0, 1'b1, 8'h30, 8'h00, 2,  0,  1,  0, 1, 1'b0, 8'h55, 2,  1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", {write_ready, read_valid, busy, timeout, mem_req, mem_we}, 32'h0);
    check("rst_buses", {mem_addr, mem_wdata, read_data}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {busy, mem_req, timeout}, 32'h0);

    // Directed vector table
    foreach (vecs[i]) begin
      clear_stats();
      do_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].ack_dly);
      check($sformatf("v%0d_write_ready", i), n_wr_ready, vecs[i].exp_wr_ready);
      check($sformatf("v%0d_read_valid", i), n_rd_valid, vecs[i].exp_rd_valid);
      check($sformatf("v%0d_mem_writes", i), n_mem_wr, vecs[i].exp_mem_wr);
      check($sformatf("v%0d_mem_reads", i), n_mem_rd, vecs[i].exp_mem_rd);
      check($sformatf("v%0d_timeout", i), timeout, vecs[i].exp_timeout);
      check($sformatf("v%0d_read_data", i), read_data, vecs[i].exp_rdata);
      check($sformatf("v%0d_req_run", i), max_run, vecs[i].exp_run);
      check($sformatf("v%0d_busy_falls", i), n_busy_fall, vecs[i].exp_busy_fall);
      check($sformatf("v%0d_we_stable", i), we_flips, 0);
      check($sformatf("v%0d_mem_req_low", i), mem_req, 1'b0);
      if (vecs[i].exp_mem_wr != 0) begin
        check($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].addr);
        check($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].wdata);
      end
      if (vecs[i].exp_timeout) begin
        check($sformatf("v%0d_timeout_busy", i), busy, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check($sformatf("v%0d_clear_timeout", i), timeout, 1'b0);
        check($sformatf("v%0d_clear_idle", i), busy, 1'b0);
        @(negedge clk);
      end
    end

    // Second write request while busy is dropped, not queued
    clear_stats();
    mem_ack_delay = 4;
    wr_req = 1'b1; addr = 8'h50; wdata = 8'h11;
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b1; addr = 8'h51; wdata = 8'h22;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_req_mem_writes", n_mem_wr, 1);
    check("busy_req_mem_reads", n_mem_rd, 0);
    check("busy_req_wr_addr", last_wr_addr, 8'h50);
    check("busy_req_wr_data", last_wr_data, 8'h11);
    check("busy_req_ready", n_wr_ready, 1);
    check("busy_req_idle", busy, 1'b0);

    // Ack with no request outstanding is ignored
    clear_stats();
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ack_pulses", n_wr_ready + n_rd_valid, 0);
    check("stray_ack_idle", {busy, mem_req}, 2'b00);

    // i_clear during a live write does not disturb it
    clear_stats();
    mem_ack_delay = 3;
    wr_req = 1'b1; addr = 8'h60; wdata = 8'h7E;
    @(negedge clk);
    wr_req = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    check("clear_live_ready", n_wr_ready, 1);
    check("clear_live_run", max_run, 3);
    check("clear_live_wdata", last_wr_data, 8'h7E);

    // Async reset in the middle of a read
    clear_stats();
    mem_ack_delay = 0;
    rd_req = 1'b1; addr = 8'h40;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_req", mem_req, 1'b1);
    check("pre_rst_rdata", read_data, 8'h55);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", {write_ready, read_valid, busy, timeout, mem_req, mem_we}, 32'h0);
    check("async_rst_buses", {mem_addr, mem_wdata, read_data}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_valid", n_rd_valid, 0);
    clear_stats();
    do_txn(1'b0, 1'b1, 8'h40, 8'h00, 1);
    check("post_rst_read_valid", n_rd_valid, 1);
    check("post_rst_read_data", read_data, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
